// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a multicycle RISC-V core. It walks each instruction through
// fetch, decode, execute, memory and writeback over a single shared memory
// with a ready handshake. It produces every datapath enable and mux select,
// and it drives the ALU operation. ECALL parks the machine in HALT until reset.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   opcode      in   IR[6:0]
//   funct3      in   IR[14:12]
//   funct7_5    in   IR[30]; selects SUB for R-type funct3=000
//   alu_bcond   in   branch condition from the ALU (same cycle)
//   mem_ready   in   memory completed the current read/write this cycle
//   mem_read    out  memory read request
//   mem_write   out  memory write request
//   i_or_d      out  memory address select: 0 = PC, 1 = ALUOut
//   ir_write    out  latch IR and MDR
//   pc_write    out  update PC
//   pc_source   out  PC source: 0 = ALU result, 1 = ALUOut
//   reg_write   out  register file write
//   mem_to_reg  out  write data: 0 = ALUOut, 1 = MDR, 2 = ALU result
//   alu_src_a   out  ALU operand A: 0 = PC, 1 = rs1 (A register)
//   alu_src_b   out  ALU operand B: 0 = rs2 (B register), 1 = 4, 2 = immediate
//   alu_op      out  ALU operation code
//   halted      out  high only while parked in HALT
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int ALU_OP_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              opcode,
    input  logic [2:0]              funct3,
    input  logic                    funct7_5,
    input  logic                    alu_bcond,
    input  logic                    mem_ready,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    i_or_d,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    pc_source,
    output logic                    reg_write,
    output logic [1:0]              mem_to_reg,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    halted
);

    // ALU operation codes shared with the datapath ALU.
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BEQ = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BNE = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BLT = ALU_OP_WIDTH'(9);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BGE = ALU_OP_WIDTH'(10);

    // Major opcodes that the FSM distinguishes.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    // Mux select encodings.
    localparam logic       SRC_A_PC   = 1'b0;
    localparam logic       SRC_A_RS1  = 1'b1;
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;
    localparam logic [1:0] WD_ALUOUT  = 2'd0;
    localparam logic [1:0] WD_MDR     = 2'd1;
    localparam logic [1:0] WD_ALU     = 2'd2;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_JWB  = 3'd5,
        S_PC4  = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t                    r_state;
    state_t                    w_nextState;
    logic [ALU_OP_WIDTH-1:0]   w_arithOp;
    logic [ALU_OP_WIDTH-1:0]   w_branchOp;

    // Arithmetic and branch-compare operations decoded from funct3. SUB is
    // layered on top of w_arithOp only for R-type, since I-type funct7 bits
    // belong to the immediate.
    always_comb begin
        w_arithOp  = ALU_ADD;
        w_branchOp = ALU_BEQ;
        case (funct3)
            3'b001:  w_arithOp = ALU_SLL;
            3'b100:  w_arithOp = ALU_XOR;
            3'b101:  w_arithOp = ALU_SRL;
            3'b110:  w_arithOp = ALU_OR;
            3'b111:  w_arithOp = ALU_AND;
            default: w_arithOp = ALU_ADD;
        endcase
        case (funct3)
            3'b001:  w_branchOp = ALU_BNE;
            3'b100:  w_branchOp = ALU_BLT;
            3'b101:  w_branchOp = ALU_BGE;
            default: w_branchOp = ALU_BEQ;
        endcase
    end

    // State register. Reset always restarts fetch, including from HALT or
    // from the middle of a memory wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Outputs and next state. Outputs are combinational because they react
    // in the same cycle to mem_ready (IR latch, leaving a memory wait) and
    // to alu_bcond (taken branch). Reset overrides everything at the end so
    // that requests drop in the very cycle reset is seen.
    always_comb begin
        w_nextState = r_state;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_source   = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = WD_ALUOUT;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_RS2;
        alu_op      = ALU_ADD;
        halted      = 1'b0;

        case (r_state)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write    = 1'b1;
                    w_nextState = S_ID;
                end
            end

            // PC+imm is computed here so ALUOut already holds the branch or
            // JAL target when a later state needs it.
            S_ID: begin
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_ECALL:  w_nextState = S_HALT;
                    OP_JAL:    w_nextState = S_JWB;
                    OP_R, OP_IARITH, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR:
                               w_nextState = S_EX;
                    default:   w_nextState = S_PC4;
                endcase
            end

            S_EX: begin
                alu_src_a = SRC_A_RS1;
                case (opcode)
                    OP_R: begin
                        alu_src_b   = SRC_B_RS2;
                        alu_op      = (funct3 == 3'b000 && funct7_5) ? ALU_SUB : w_arithOp;
                        w_nextState = S_WB;
                    end
                    OP_IARITH: begin
                        alu_src_b   = SRC_B_IMM;
                        alu_op      = w_arithOp;
                        w_nextState = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b   = SRC_B_IMM;
                        w_nextState = S_MEM;
                    end
                    // Taken branches load the target latched in ID straight
                    // from ALUOut and skip the PC+4 step.
                    OP_BRANCH: begin
                        alu_src_b = SRC_B_RS2;
                        alu_op    = w_branchOp;
                        if (alu_bcond) begin
                            pc_write    = 1'b1;
                            pc_source   = 1'b1;
                            w_nextState = S_IF;
                        end else begin
                            w_nextState = S_PC4;
                        end
                    end
                    OP_JALR: begin
                        alu_src_b   = SRC_B_IMM;
                        w_nextState = S_JWB;
                    end
                    default: begin
                        w_nextState = S_PC4;
                    end
                endcase
            end

            // The request stays asserted for as long as memory needs.
            S_MEM: begin
                i_or_d = 1'b1;
                if (opcode == OP_LOAD) begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        w_nextState = S_WB;
                    end
                end else if (opcode == OP_STORE) begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        w_nextState = S_PC4;
                    end
                end else begin
                    w_nextState = S_PC4;
                end
            end

            S_WB: begin
                reg_write   = 1'b1;
                mem_to_reg  = (opcode == OP_LOAD) ? WD_MDR : WD_ALUOUT;
                w_nextState = S_PC4;
            end

            // Link and jump in one cycle: the ALU forms PC+4 for rd while
            // the PC takes the target already sitting in ALUOut.
            S_JWB: begin
                alu_src_a   = SRC_A_PC;
                alu_src_b   = SRC_B_FOUR;
                reg_write   = 1'b1;
                mem_to_reg  = WD_ALU;
                pc_write    = 1'b1;
                pc_source   = 1'b1;
                w_nextState = S_IF;
            end

            S_PC4: begin
                alu_src_a   = SRC_A_PC;
                alu_src_b   = SRC_B_FOUR;
                pc_write    = 1'b1;
                pc_source   = 1'b0;
                w_nextState = S_IF;
            end

            S_HALT: begin
                halted      = 1'b1;
                w_nextState = S_HALT;
            end
        endcase

        if (reset) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_source  = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = WD_ALUOUT;
            alu_src_a  = SRC_A_PC;
            alu_src_b  = SRC_B_RS2;
            alu_op     = ALU_ADD;
            halted     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. Each instruction is described as
// the list of per-cycle control words that the instruction must produce.
// Those words are built from small step helpers (fetch, decode, execute,
// memory, writeback, link-jump, PC+4, halt). A single compare process
// checks the DUT against the queued word on every cycle. A few literal
// spot checks pin individual signals to hand-computed values.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLL = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd4;
    localparam logic [3:0] ALU_OR  = 4'd5;
    localparam logic [3:0] ALU_AND = 4'd6;
    localparam logic [3:0] ALU_BEQ = 4'd7;
    localparam logic [3:0] ALU_BNE = 4'd8;
    localparam logic [3:0] ALU_BLT = 4'd9;
    localparam logic [3:0] ALU_BGE = 4'd10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic       iOrD;
        logic       irWrite;
        logic       pcWrite;
        logic       pcSource;
        logic       regWrite;
        logic [1:0] memToReg;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [3:0] aluOp;
        logic       halted;
    } ctrl_t;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       alu_bcond;
    logic       mem_ready;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_source;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       halted;

    multicycle_control #(.ALU_OP_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .alu_bcond  (alu_bcond),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .halted     (halted)
    );

    // 10-unit clock; rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctrl_t expQ[$];
    string tagQ[$];
    string curTest;
    int    compared   = 0;
    int    mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic ctrl_t dutCtrl();
        ctrl_t r;
        r.memRead  = mem_read;
        r.memWrite = mem_write;
        r.iOrD     = i_or_d;
        r.irWrite  = ir_write;
        r.pcWrite  = pc_write;
        r.pcSource = pc_source;
        r.regWrite = reg_write;
        r.memToReg = mem_to_reg;
        r.aluSrcA  = alu_src_a;
        r.aluSrcB  = alu_src_b;
        r.aluOp    = alu_op;
        r.halted   = halted;
        return r;
    endfunction

    // Compare process: one queued control word per cycle, checked mid-cycle
    // on the falling edge once inputs and state have settled.
    always @(negedge clk) begin : compareProc
        ctrl_t expWord;
        string tag;
        if (expQ.size() > 0) begin
            expWord = expQ.pop_front();
            tag     = tagQ.pop_front();
            checkOutput(tag, {15'b0, dutCtrl()}, {15'b0, expWord});
        end
    end

    // ---- Control-word model: one helper per step of an instruction ----
    function automatic ctrl_t idleWord();
        ctrl_t r;
        r       = '0;
        r.aluOp = ALU_ADD;
        return r;
    endfunction

    function automatic ctrl_t fetchWord(input logic ready);
        ctrl_t r = idleWord();
        r.memRead = 1'b1;
        r.irWrite = ready;
        return r;
    endfunction

    function automatic ctrl_t decodeWord();
        ctrl_t r = idleWord();
        r.aluSrcB = 2'd2;
        return r;
    endfunction

    function automatic ctrl_t execWord(input logic srcA, input logic [1:0] srcB, input logic [3:0] op);
        ctrl_t r = idleWord();
        r.aluSrcA = srcA;
        r.aluSrcB = srcB;
        r.aluOp   = op;
        return r;
    endfunction

    function automatic ctrl_t memWord(input logic isLoad);
        ctrl_t r = idleWord();
        r.iOrD     = 1'b1;
        r.memRead  = isLoad;
        r.memWrite = ~isLoad;
        return r;
    endfunction

    function automatic ctrl_t wbWord(input logic isLoad);
        ctrl_t r = idleWord();
        r.regWrite = 1'b1;
        r.memToReg = isLoad ? 2'd1 : 2'd0;
        return r;
    endfunction

    function automatic ctrl_t linkJumpWord();
        ctrl_t r = idleWord();
        r.aluSrcB  = 2'd1;
        r.regWrite = 1'b1;
        r.memToReg = 2'd2;
        r.pcWrite  = 1'b1;
        r.pcSource = 1'b1;
        return r;
    endfunction

    function automatic ctrl_t pc4Word();
        ctrl_t r = idleWord();
        r.aluSrcB = 2'd1;
        r.pcWrite = 1'b1;
        return r;
    endfunction

    function automatic ctrl_t haltWord();
        ctrl_t r = idleWord();
        r.halted = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] arithOp(input logic [2:0] f3, input logic subSel);
        logic [3:0] tbl [0:7];
        tbl = '{ALU_ADD, ALU_SLL, ALU_ADD, ALU_ADD, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (f3 == 3'b000 && subSel) return ALU_SUB;
        return tbl[f3];
    endfunction

    function automatic logic [3:0] branchOp(input logic [2:0] f3);
        logic [3:0] tbl [0:7];
        tbl = '{ALU_BEQ, ALU_BNE, ALU_BEQ, ALU_BEQ, ALU_BLT, ALU_BGE, ALU_BEQ, ALU_BEQ};
        return tbl[f3];
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // ---- Stimulus ----
    // Inputs change 1 unit after a rising edge; drive() returns before the
    // falling edge so literal spot checks land in the same cycle.
    task automatic drive(input logic rst, input logic ready, input logic bcond,
                         input ctrl_t expWord, input string tag);
        reset     = rst;
        mem_ready = ready;
        alu_bcond = bcond;
        expQ.push_back(expWord);
        tagQ.push_back({curTest, "/", tag});
        #3;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic ready, input logic bcond,
                                 input ctrl_t expWord, input string tag);
        drive(rst, ready, bcond, expWord, tag);
        nextCycle();
    endtask

    // Runs one non-ECALL instruction from IF back to the following IF.
    // memWait is the number of MEM cycles with mem_ready low.
    task automatic runInstr(input string name, input logic [6:0] opc, input logic [2:0] f3,
                            input logic f75, input logic bcond, input int memWait);
        ctrl_t e;
        logic  isLoad;
        curTest  = name;
        opcode   = opc;
        funct3   = f3;
        funct7_5 = f75;
        isLoad   = (opc == OP_LOAD);
        applyStimulus(1'b0, 1'b1, rnd(), fetchWord(1'b1), "IF");
        applyStimulus(1'b0, rnd(), rnd(), decodeWord(), "ID");
        case (opc)
            OP_JAL: begin
                applyStimulus(1'b0, rnd(), rnd(), linkJumpWord(), "JWB");
            end
            OP_R: begin
                applyStimulus(1'b0, rnd(), rnd(), execWord(1'b1, 2'd0, arithOp(f3, f75)), "EX");
                applyStimulus(1'b0, rnd(), rnd(), wbWord(1'b0), "WB");
                applyStimulus(1'b0, rnd(), rnd(), pc4Word(), "PC4");
            end
            OP_I: begin
                applyStimulus(1'b0, rnd(), rnd(), execWord(1'b1, 2'd2, arithOp(f3, 1'b0)), "EX");
                applyStimulus(1'b0, rnd(), rnd(), wbWord(1'b0), "WB");
                applyStimulus(1'b0, rnd(), rnd(), pc4Word(), "PC4");
            end
            OP_LOAD, OP_STORE: begin
                applyStimulus(1'b0, rnd(), rnd(), execWord(1'b1, 2'd2, ALU_ADD), "EX");
                for (int i = 0; i < memWait; i++) begin
                    applyStimulus(1'b0, 1'b0, rnd(), memWord(isLoad), "MEMwait");
                end
                applyStimulus(1'b0, 1'b1, rnd(), memWord(isLoad), "MEM");
                if (isLoad) begin
                    applyStimulus(1'b0, rnd(), rnd(), wbWord(1'b1), "WB");
                end
                applyStimulus(1'b0, rnd(), rnd(), pc4Word(), "PC4");
            end
            OP_BRANCH: begin
                e = execWord(1'b1, 2'd0, branchOp(f3));
                if (bcond) begin
                    e.pcWrite  = 1'b1;
                    e.pcSource = 1'b1;
                end
                applyStimulus(1'b0, rnd(), bcond, e, "EX");
                if (!bcond) begin
                    applyStimulus(1'b0, rnd(), rnd(), pc4Word(), "PC4");
                end
            end
            OP_JALR: begin
                applyStimulus(1'b0, rnd(), rnd(), execWord(1'b1, 2'd2, ALU_ADD), "EX");
                applyStimulus(1'b0, rnd(), rnd(), linkJumpWord(), "JWB");
            end
            default: begin
                applyStimulus(1'b0, rnd(), rnd(), pc4Word(), "PC4");
            end
        endcase
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        alu_bcond = 1'b0;
        opcode    = 7'd0;
        funct3    = 3'd0;
        funct7_5  = 1'b0;
        nextCycle();

        // Reset: everything idle, halted low, ADD on the ALU.
        curTest = "reset";
        applyStimulus(1'b1, 1'b1, 1'b1, idleWord(), "r0");
        drive(1'b1, 1'b1, 1'b1, idleWord(), "r1");
        checkOutput("reset_halted_lit", 32'(halted), 32'd0);
        checkOutput("reset_alu_op_lit", 32'(alu_op), 32'd0);
        nextCycle();

        // R-type SUB with literal spot checks; back in IF after 5 cycles.
        curTest  = "rsub";
        opcode   = OP_R;
        funct3   = 3'b000;
        funct7_5 = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, fetchWord(1'b1), "IF");
        applyStimulus(1'b0, 1'b1, 1'b0, decodeWord(), "ID");
        drive(1'b0, 1'b1, 1'b0, execWord(1'b1, 2'd0, ALU_SUB), "EX");
        checkOutput("rsub_alu_op_lit", 32'(alu_op), 32'd1);
        nextCycle();
        drive(1'b0, 1'b1, 1'b0, wbWord(1'b0), "WB");
        checkOutput("rsub_wb_lit", {29'b0, reg_write, mem_to_reg}, 32'h4);
        nextCycle();
        drive(1'b0, 1'b1, 1'b0, pc4Word(), "PC4");
        checkOutput("rsub_pc4_lit", {30'b0, pc_write, pc_source}, 32'h2);
        nextCycle();
        drive(1'b0, 1'b0, 1'b0, fetchWord(1'b0), "IF");
        checkOutput("rsub_back_in_if_lit", {30'b0, mem_read, i_or_d}, 32'h2);
        nextCycle();

        // Every funct3 for R-type (funct7_5 toggling) and I-type (funct7_5 set).
        for (int f = 0; f < 8; f++) begin
            runInstr($sformatf("r_f3_%0d", f), OP_R, 3'(f), f[0], 1'b0, 0);
        end
        runInstr("r_sub_again", OP_R, 3'b000, 1'b1, 1'b0, 0);
        for (int f = 0; f < 8; f++) begin
            runInstr($sformatf("i_f3_%0d", f), OP_I, 3'(f), 1'b1, 1'b0, 0);
        end

        // Fetch stalls for two cycles, then a LOAD that waits 3 cycles in MEM.
        curTest = "fetchwait";
        applyStimulus(1'b0, 1'b0, 1'b1, fetchWord(1'b0), "IFwait0");
        applyStimulus(1'b0, 1'b0, 1'b0, fetchWord(1'b0), "IFwait1");
        runInstr("load_wait3", OP_LOAD, 3'b010, 1'b0, 1'b0, 3);
        runInstr("load_nowait", OP_LOAD, 3'b010, 1'b0, 1'b0, 0);
        runInstr("store_nowait", OP_STORE, 3'b010, 1'b0, 1'b0, 0);
        runInstr("store_wait2", OP_STORE, 3'b010, 1'b1, 1'b0, 2);

        // Branches: taken (3 cycles) and not taken (4 cycles).
        runInstr("bne_taken", OP_BRANCH, 3'b001, 1'b0, 1'b1, 0);
        runInstr("bne_not", OP_BRANCH, 3'b001, 1'b0, 1'b0, 0);
        runInstr("beq_taken", OP_BRANCH, 3'b000, 1'b0, 1'b1, 0);
        runInstr("blt_not", OP_BRANCH, 3'b100, 1'b0, 1'b0, 0);
        runInstr("bge_taken", OP_BRANCH, 3'b101, 1'b1, 1'b1, 0);
        runInstr("bf3_011_taken", OP_BRANCH, 3'b011, 1'b0, 1'b1, 0);

        // Jumps and opcodes that fall through as NOPs.
        runInstr("jal", OP_JAL, 3'b000, 1'b0, 1'b0, 0);
        runInstr("jalr", OP_JALR, 3'b000, 1'b0, 1'b0, 0);
        runInstr("lui_nop", OP_LUI, 3'b000, 1'b0, 1'b0, 0);
        runInstr("auipc_nop", OP_AUIPC, 3'b000, 1'b0, 1'b0, 0);
        runInstr("fence_nop", OP_FENCE, 3'b000, 1'b0, 1'b0, 0);

        // JAL one-cycle link and jump, spot-checked literally.
        curTest  = "jal_lit";
        opcode   = OP_JAL;
        applyStimulus(1'b0, 1'b1, 1'b0, fetchWord(1'b1), "IF");
        applyStimulus(1'b0, 1'b1, 1'b0, decodeWord(), "ID");
        drive(1'b0, 1'b1, 1'b0, linkJumpWord(), "JWB");
        checkOutput("jal_jwb_lit", {27'b0, reg_write, mem_to_reg, pc_write, pc_source}, 32'h1B);
        nextCycle();

        // Reset while a STORE waits in MEM.
        curTest  = "store_reset";
        opcode   = OP_STORE;
        funct3   = 3'b010;
        applyStimulus(1'b0, 1'b1, 1'b0, fetchWord(1'b1), "IF");
        applyStimulus(1'b0, 1'b0, 1'b0, decodeWord(), "ID");
        applyStimulus(1'b0, 1'b0, 1'b0, execWord(1'b1, 2'd2, ALU_ADD), "EX");
        applyStimulus(1'b0, 1'b0, 1'b0, memWord(1'b0), "MEMwait0");
        applyStimulus(1'b0, 1'b0, 1'b0, memWord(1'b0), "MEMwait1");
        drive(1'b1, 1'b0, 1'b0, idleWord(), "RST");
        checkOutput("store_reset_mem_write_lit", 32'(mem_write), 32'd0);
        nextCycle();
        drive(1'b0, 1'b0, 1'b0, fetchWord(1'b0), "IF");
        checkOutput("store_reset_refetch_lit", {30'b0, mem_read, i_or_d}, 32'h2);
        nextCycle();

        // ECALL: halt for 12 cycles regardless of inputs, then reset.
        curTest  = "ecall";
        opcode   = OP_ECALL;
        funct3   = 3'b000;
        applyStimulus(1'b0, 1'b1, 1'b0, fetchWord(1'b1), "IF");
        applyStimulus(1'b0, 1'b1, 1'b0, decodeWord(), "ID");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, rnd(), rnd(), haltWord(), $sformatf("HALT%0d", i));
        end
        drive(1'b0, 1'b1, 1'b1, haltWord(), "HALTlast");
        checkOutput("ecall_halted_lit", 32'(halted), 32'd1);
        nextCycle();
        drive(1'b1, 1'b1, 1'b1, idleWord(), "RST");
        checkOutput("ecall_reset_halted_lit", 32'(halted), 32'd0);
        nextCycle();
        drive(1'b0, 1'b0, 1'b0, fetchWord(1'b0), "IF");
        checkOutput("ecall_after_reset_lit", {30'b0, halted, mem_read}, 32'h1);
        nextCycle();

        // One more fetched instruction proves the machine runs again.
        runInstr("post_halt_add", OP_I, 3'b000, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle RISC-V control FSM. It is the upstream end of the ALU interface: it drives `alu_op` and the ALU operand selects, and consumes `alu_bcond` back from the ALU.
- It sequences fetch, decode, execute, memory and writeback over a shared memory that has a ready handshake.
- It produces every datapath write enable and mux select, and halts on ECALL.

Parameters:
- `ALU_OP_WIDTH`, 4, width of `alu_op`. It matches the `ALU_*` codes in opcodes.v.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  7  IR[6:0].
- `funct3`  in  3  IR[14:12].
- `funct7_5`  in  1  IR[30].
- `alu_bcond`  in  1  branch condition from the ALU, combinational in the same cycle.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  latch IR and MDR.
- `pc_write`  out  1  update PC.
- `pc_source`  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- `reg_write`  out  1  register file write.
- `mem_to_reg`  out  2  register write data: 0 = ALUOut, 1 = MDR, 2 = ALU result.
- `alu_src_a`  out  1  ALU operand A: 0 = PC, 1 = A register (rs1).
- `alu_src_b`  out  2  ALU operand B: 0 = B register (rs2), 1 = constant 4, 2 = immediate.
- `alu_op`  out  `ALU_OP_WIDTH`  ALU operation code.
- `halted`  out  1  sticky halt flag.

Behaviour:
- Datapath contract: one clock; reset is synchronous and active-high. The datapath latches ALUOut on every clock edge.
- States, 3-bit encoding: IF, ID, EX, MEM, WB, JWB, PC4, HALT.
- Reset: state returns to IF at the clock edge. While `reset` is high, all enables are 0, `halted` is 0 and `alu_op` is `ALU_ADD`.
- Default outputs in every state: all enables 0, all selects 0, `alu_op` = `ALU_ADD`. `halted` is 1 only in HALT.
- IF:
  - Drives `mem_read`=1, `i_or_d`=0.
  - If `mem_ready`=1: `ir_write`=1 and the next state is ID. Otherwise the FSM stays in IF.
- ID:
  - Drives `alu_src_a`=PC, `alu_src_b`=imm, ADD, so ALUOut receives PC+imm (branch/JAL target).
  - Next state:
    - ECALL (1110011) goes to HALT.
    - JAL (1101111) goes to JWB.
    - R (0110011), I-arith (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011) and JALR (1100111) go to EX.
    - Any other opcode goes to PC4 and executes as a NOP.
- EX, R-type:
  - Drives `alu_src_a`=rs1, `alu_src_b`=B. Next state is WB.
  - `funct3` mapping: 000 gives ADD, or SUB when `funct7_5`=1; 001 SLL; 100 XOR; 101 SRL; 110 OR; 111 AND.
  - Any other `funct3` gives ADD.
- EX, I-arith: drives `alu_src_a`=rs1, `alu_src_b`=imm. Same `funct3` map as R-type, but `funct7_5` is ignored. Next state is WB.
- EX, LOAD/STORE: drives rs1+imm, ADD. Next state is MEM.
- EX, BRANCH:
  - Drives `alu_src_a`=rs1, `alu_src_b`=B.
  - `funct3` mapping: 000 BEQ, 001 BNE, 100 BLT, 101 BGE. Any other `funct3` gives BEQ.
  - If `alu_bcond`=1: `pc_write`=1, `pc_source`=ALUOut, next state IF. Otherwise next state is PC4.
- EX, JALR: drives rs1+imm, ADD, so ALUOut receives the target. Next state is JWB.
- MEM:
  - `i_or_d`=1.
  - LOAD: `mem_read`=1. On `mem_ready` the FSM goes to WB, with `ir_write`=0; the MDR latch is owned by the datapath on `mem_ready`.
  - STORE: `mem_write`=1. On `mem_ready` the FSM goes to PC4.
  - The request is held steady until `mem_ready`; the wait is unbounded.
- WB: `reg_write`=1. `mem_to_reg` is 1 for LOAD, 0 otherwise. Next state is PC4.
- JWB:
  - Drives `alu_src_a`=PC, `alu_src_b`=4, ADD.
  - Same cycle: `reg_write`=1 with `mem_to_reg`=2 (rd receives PC+4), and `pc_write`=1 with `pc_source`=ALUOut.
  - Next state is IF.
- PC4: drives PC+4, `pc_write`=1, `pc_source`=ALU result. Next state is IF.
- HALT: all enables 0, `halted`=1. The FSM leaves HALT only via reset.
- Reset mid-memory-wait: `mem_read`/`mem_write` drop to 0 in the reset cycle, and fetch restarts from IF.
- Cycle counts with `mem_ready` always 1:
  - R/I: 5.
  - LOAD: 6.
  - STORE: 5.
  - Branch taken: 3; branch not taken: 4.
  - JAL: 3.
  - JALR: 4.

Test Plan:
- R-type SUB: `opcode`=0110011, `funct3`=000, `funct7_5`=1, `mem_ready`=1.
  - Required sequence: IF, ID, EX with `alu_op`=`ALU_SUB`, WB with `reg_write`=1 and `mem_to_reg`=0, PC4 with `pc_write`=1.
  - Back in IF at cycle 5.
- LOAD with `mem_ready` low for 3 cycles in MEM:
  - `mem_read`=1 and `i_or_d`=1 are held for 4 cycles.
  - Then WB with `mem_to_reg`=1, then PC4.
- BNE:
  - `alu_bcond`=1 in EX: `pc_write`=1 and `pc_source`=1 that cycle, next state IF, total 3 cycles.
  - `alu_bcond`=0: PC4 is visited, total 4 cycles.
- JAL: IF, ID, then JWB with `reg_write`=1, `mem_to_reg`=2, `pc_write`=1, `pc_source`=1, all in one cycle.
- ECALL:
  - After ID, `halted`=1 and all enables are 0 for 10 or more cycles.
  - Asserting `reset` then gives `halted`=0 and state IF on the next edge.
- Reset during a STORE MEM wait: `mem_write` is 0 in the reset cycle, and the next cycle is IF with `mem_read`=1.
